array_cfg_sequencer: RTL and testbench

ARRAY_CFG_SEQUENCER -- requirements
Module: array_cfg_sequencer

---
 rtl/array_cfg_sequencer_if.sv | 48 ++++
 rtl/array_cfg_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_array_cfg_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/array_cfg_sequencer_if.sv
// ============================================================================
// Module      : array_cfg_sequencer_if
// Description : Request / row-configuration bus of the array config sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface array_cfg_sequencer_if #(
    parameter int ROWS  = 16,
    parameter int COLS  = 16,
    parameter int DIM_W = 8
);
    localparam int c_row_w = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic               req_valid;
    logic               req_ready;
    logic [1:0]         req_mode;
    logic [DIM_W-1:0]   req_height;
    logic [DIM_W-1:0]   req_width;
    logic               abort;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [c_row_w-1:0] cfg_row;
    logic [2*COLS-1:0]  cfg_mux;
    logic [COLS-1:0]    cfg_mac_en;
    logic               cfg_last;
    logic               done;
    logic               err;
    logic [1:0]         active_mode;
    logic [DIM_W-1:0]   active_height;
    logic [DIM_W-1:0]   active_width;

    // Requester and array side, driving the sequencer.
    modport master (
        output req_valid, req_mode, req_height, req_width, abort, cfg_ready,
        input  req_ready, cfg_valid, cfg_row, cfg_mux, cfg_mac_en, cfg_last,
        input  done, err, active_mode, active_height, active_width
    );

    // The sequencer itself.
    modport slave (
        input  req_valid, req_mode, req_height, req_width, abort, cfg_ready,
        output req_ready, cfg_valid, cfg_row, cfg_mux, cfg_mac_en, cfg_last,
        output done, err, active_mode, active_height, active_width
    );
endinterface

`default_nettype wire

// File: rtl/array_cfg_sequencer.sv
// ============================================================================
// Module      : array_cfg_sequencer
// Description : Validates a PE-array dataflow request and streams one
//               configuration beat per array row.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module array_cfg_sequencer #(
    parameter int ROWS  = 16,
    parameter int COLS  = 16,
    parameter int DIM_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    array_cfg_sequencer_if.slave  bus
);
    localparam int                 c_row_w    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [c_row_w-1:0] c_last_row = c_row_w'(ROWS - 1);
    localparam logic [DIM_W-1:0]   c_rows_dim = DIM_W'(ROWS);
    localparam logic [DIM_W-1:0]   c_cols_dim = DIM_W'(COLS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [1:0]         r_req_mode;
    logic [DIM_W-1:0]   r_req_height;
    logic [DIM_W-1:0]   r_req_width;

    logic               r_cfg_valid;
    logic               w_cfg_valid_nxt;
    logic [c_row_w-1:0] r_cfg_row;
    logic [c_row_w-1:0] w_row_nxt;
    logic [2*COLS-1:0]  r_cfg_mux;
    logic [2*COLS-1:0]  w_beat_mux;
    logic [COLS-1:0]    r_cfg_mac_en;
    logic [COLS-1:0]    w_beat_mac;
    logic               r_cfg_last;
    logic               r_err;
    logic               w_err_nxt;

    logic [1:0]         r_active_mode;
    logic [DIM_W-1:0]   r_active_height;
    logic [DIM_W-1:0]   r_active_width;

    logic               w_capture;
    logic               w_commit;
    logic               w_illegal;
    logic               w_row_in;
    logic [1:0]         w_mux_code;

    assign w_illegal = (r_req_mode == 2'b11) ||
                       (r_req_height == '0) || (r_req_width == '0) ||
                       (r_req_height > c_rows_dim) || (r_req_width > c_cols_dim);

    // Beat contents are derived from the row about to be presented, so the
    // output registers simply reload the same values while stalled.
    assign w_row_in   = DIM_W'(w_row_nxt) < r_req_height;
    assign w_mux_code = r_req_mode + 2'd1;

    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam logic [DIM_W-1:0] c_col = DIM_W'(c);
        assign w_beat_mac[c]       = w_row_in && (c_col < r_req_width);
        assign w_beat_mux[2*c +: 2] = w_beat_mac[c] ? w_mux_code : 2'b00;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cfg_valid_nxt = r_cfg_valid;
        w_row_nxt       = r_cfg_row;
        w_err_nxt       = 1'b0;
        w_capture       = 1'b0;
        w_commit        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                w_row_nxt = '0;
                if (bus.abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_illegal) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cfg_valid_nxt = 1'b1;
                    w_state_nxt     = ST_STREAM;
                end
            end
            ST_STREAM: begin
                // Abort wins even over a coincident last-beat transfer.
                if (bus.abort) begin
                    w_cfg_valid_nxt = 1'b0;
                    w_row_nxt       = '0;
                    w_state_nxt     = ST_IDLE;
                end else if (bus.cfg_ready) begin
                    if (r_cfg_row == c_last_row) begin
                        w_cfg_valid_nxt = 1'b0;
                        w_row_nxt       = '0;
                        w_commit        = 1'b1;
                        w_state_nxt     = ST_DONE;
                    end else begin
                        w_row_nxt = r_cfg_row + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_cfg_valid_nxt = 1'b0;
                w_row_nxt       = '0;
                w_state_nxt     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req_mode   <= 2'b00;
            r_req_height <= '0;
            r_req_width  <= '0;
        end else if (w_capture) begin
            r_req_mode   <= bus.req_mode;
            r_req_height <= bus.req_height;
            r_req_width  <= bus.req_width;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cfg_valid  <= 1'b0;
            r_cfg_row    <= '0;
            r_cfg_mux    <= '0;
            r_cfg_mac_en <= '0;
            r_cfg_last   <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_cfg_valid  <= w_cfg_valid_nxt;
            r_cfg_row    <= w_row_nxt;
            r_cfg_mux    <= w_cfg_valid_nxt ? w_beat_mux : '0;
            r_cfg_mac_en <= w_cfg_valid_nxt ? w_beat_mac : '0;
            r_cfg_last   <= w_cfg_valid_nxt && (w_row_nxt == c_last_row);
            r_err        <= w_err_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_active_mode   <= 2'b11;
            r_active_height <= '0;
            r_active_width  <= '0;
        end else if (w_commit) begin
            r_active_mode   <= r_req_mode;
            r_active_height <= r_req_height;
            r_active_width  <= r_req_width;
        end
    end

    assign bus.req_ready     = (r_state == ST_IDLE);
    assign bus.done          = (r_state == ST_DONE);
    assign bus.err           = r_err;
    assign bus.cfg_valid     = r_cfg_valid;
    assign bus.cfg_row       = r_cfg_row;
    assign bus.cfg_mux       = r_cfg_mux;
    assign bus.cfg_mac_en    = r_cfg_mac_en;
    assign bus.cfg_last      = r_cfg_last;
    assign bus.active_mode   = r_active_mode;
    assign bus.active_height = r_active_height;
    assign bus.active_width  = r_active_width;

endmodule

`default_nettype wire

// File: tb/tb_array_cfg_sequencer.sv
// ============================================================================
// Module      : tb_array_cfg_sequencer
// Description : Scoreboard bench for array_cfg_sequencer with a 4x4 array.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_array_cfg_sequencer;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int DIM_W = 8;
    localparam int K_BEAT = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;

    typedef struct {
        int kind;
        int row;
        int mux;
        int mac;
        int last;
        int am;
        int ah;
        int aw;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cur_m = 3, cur_h = 0, cur_w = 0;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    array_cfg_sequencer_if #(.ROWS(ROWS), .COLS(COLS), .DIM_W(DIM_W)) bus ();

    array_cfg_sequencer #(.ROWS(ROWS), .COLS(COLS), .DIM_W(DIM_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk_beat(input int m, input int h, input int w, input int r);
        exp_t e;
        int code;
        code = (m == 0) ? 1 : (m == 1) ? 2 : 3;
        e = '{kind: K_BEAT, row: r, mux: 0, mac: 0, last: (r == ROWS-1) ? 1 : 0,
              am: 0, ah: 0, aw: 0};
        for (int c = 0; c < COLS; c++) begin
            if (r < h && c < w) begin
                e.mac = e.mac | (1 << c);
                e.mux = e.mux | (code << (2*c));
            end
        end
        return e;
    endfunction

    task automatic push_beats(input int m, input int h, input int w, input int n);
        for (int r = 0; r < n; r++) exp_q.push_back(mk_beat(m, h, w, r));
    endtask

    task automatic push_legal(input int m, input int h, input int w);
        push_beats(m, h, w, ROWS);
        exp_q.push_back('{kind: K_DONE, row: 0, mux: 0, mac: 0, last: 0, am: m, ah: h, aw: w});
        cur_m = m; cur_h = h; cur_w = w;
    endtask

    task automatic push_err();
        exp_q.push_back('{kind: K_ERR, row: 0, mux: 0, mac: 0, last: 0, am: 0, ah: 0, aw: 0});
    endtask

    task automatic pop_cmp(input int kind);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got kind %0d, expected nothing at %0t", kind, $time);
        end else begin
            e = exp_q.pop_front();
            chk("out_kind", kind, e.kind);
            if (kind == e.kind && kind == K_BEAT) begin
                chk("beat_row", bus.cfg_row, e.row);
                chk("beat_mux", bus.cfg_mux, e.mux);
                chk("beat_mac_en", bus.cfg_mac_en, e.mac);
                chk("beat_last", bus.cfg_last, e.last);
            end else if (kind == e.kind && kind == K_DONE) begin
                chk("done_active_mode", bus.active_mode, e.am);
                chk("done_active_height", bus.active_height, e.ah);
                chk("done_active_width", bus.active_width, e.aw);
            end
        end
    endtask

    // Monitor: every presented output event is matched against the queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.cfg_valid && bus.cfg_ready) pop_cmp(K_BEAT);
            if (bus.done) pop_cmp(K_DONE);
            if (bus.err)  pop_cmp(K_ERR);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int m, input int h, input int w);
        bus.req_valid  = 1'b1;
        bus.req_mode   = 2'(m);
        bus.req_height = DIM_W'(h);
        bus.req_width  = DIM_W'(w);
        tick();
        bus.req_valid = 1'b0;
        chk("check_req_ready", bus.req_ready, 0);
        chk("check_cfg_valid", bus.cfg_valid, 0);
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (bus.done) seen = 1;
            else tick();
        end
        chk({name, "_done_seen"}, 32'(seen), 1);
        tick();
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "_cfg_valid"}, bus.cfg_valid, 0);
        chk({name, "_done"}, bus.done, 0);
        chk({name, "_err"}, bus.err, 0);
        chk({name, "_req_ready"}, bus.req_ready, 1);
        chk({name, "_active_mode"}, bus.active_mode, cur_m);
        chk({name, "_active_height"}, bus.active_height, cur_h);
        chk({name, "_active_width"}, bus.active_width, cur_w);
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_row"}, bus.cfg_row, 0);
        chk({name, "_mux"}, bus.cfg_mux, 0);
        chk({name, "_mac_en"}, bus.cfg_mac_en, 0);
        chk({name, "_last"}, bus.cfg_last, 0);
        chk_quiet(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad_m [5] = '{1, 3, 0, 2, 0};
        int bad_h [5] = '{5, 2, 2, 0, 4};
        int bad_w [5] = '{2, 2, 0, 3, 5};
        logic [31:0] s_row, s_mux, s_mac, s_last;

        bus.req_valid  = 1'b0;
        bus.req_mode   = 2'b00;
        bus.req_height = '0;
        bus.req_width  = '0;
        bus.abort      = 1'b0;
        bus.cfg_ready  = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        reset = 1'b0;
        tick();

        // Mode 01, 2x3 region, downstream always ready.
        push_legal(1, 2, 3);
        send(1, 2, 3);
        tick();
        chk("t2_valid", bus.cfg_valid, 1);
        chk("t2_row", bus.cfg_row, 0);
        chk("t2_mac_en", bus.cfg_mac_en, 4'b0111);
        chk("t2_mux", bus.cfg_mux, 8'h2A);
        tick();
        chk("t3_row", bus.cfg_row, 1);
        chk("t3_mux", bus.cfg_mux, 8'h2A);
        tick();
        chk("t4_row", bus.cfg_row, 2);
        chk("t4_mac_en", bus.cfg_mac_en, 0);
        chk("t4_mux", bus.cfg_mux, 0);
        tick();
        chk("t5_row", bus.cfg_row, 3);
        chk("t5_last", bus.cfg_last, 1);
        tick();
        chk("t6_valid", bus.cfg_valid, 0);
        chk("t6_done", bus.done, 1);
        chk("t6_active_mode", bus.active_mode, 1);
        chk("t6_active_height", bus.active_height, 2);
        chk("t6_active_width", bus.active_width, 3);
        tick();
        chk("t7_done", bus.done, 0);
        chk("t7_req_ready", bus.req_ready, 1);

        // Rejected requests.
        for (int i = 0; i < 5; i++) begin
            push_err();
            send(bad_m[i], bad_h[i], bad_w[i]);
            tick();
            chk("rej_err", bus.err, 1);
            chk("rej_cfg_valid", bus.cfg_valid, 0);
            chk("rej_req_ready", bus.req_ready, 1);
            chk("rej_active_mode", bus.active_mode, cur_m);
            chk("rej_active_height", bus.active_height, cur_h);
            chk("rej_active_width", bus.active_width, cur_w);
            tick();
            chk("rej_err_pulse", bus.err, 0);
        end

        // Full-size request at the legal boundary.
        push_legal(2, 4, 4);
        send(2, 4, 4);
        wait_done("full");

        // Three stalled cycles on row 1.
        push_legal(0, 3, 1);
        send(0, 3, 1);
        tick();
        tick();
        bus.cfg_ready = 1'b0;
        chk("stall_row", bus.cfg_row, 1);
        chk("stall_mux", bus.cfg_mux, 8'h01);
        chk("stall_mac_en", bus.cfg_mac_en, 4'b0001);
        s_row = 32'(bus.cfg_row);
        s_mux = 32'(bus.cfg_mux);
        s_mac = 32'(bus.cfg_mac_en);
        s_last = 32'(bus.cfg_last);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stall_hold_valid", bus.cfg_valid, 1);
            chk("stall_hold_row", bus.cfg_row, s_row);
            chk("stall_hold_mux", bus.cfg_mux, s_mux);
            chk("stall_hold_mac_en", bus.cfg_mac_en, s_mac);
            chk("stall_hold_last", bus.cfg_last, s_last);
        end
        tick();
        bus.cfg_ready = 1'b1;
        wait_done("stall");

        // Abort while row 2 is presented.
        push_beats(2, 4, 4, 3);
        send(2, 4, 4);
        tick();
        tick();
        tick();
        chk("abort_row", bus.cfg_row, 2);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk_quiet("abort");
        tick();
        chk("abort_after_done", bus.done, 0);
        push_legal(1, 1, 4);
        send(1, 1, 4);
        tick();
        chk("post_abort_valid", bus.cfg_valid, 1);
        chk("post_abort_row", bus.cfg_row, 0);
        chk("post_abort_mac_en", bus.cfg_mac_en, 4'hF);
        chk("post_abort_mux", bus.cfg_mux, 8'hAA);
        wait_done("post_abort");

        // Abort coincident with the last-beat transfer.
        push_beats(1, 4, 2, 4);
        send(1, 4, 2);
        repeat (4) tick();
        chk("abort_last_flag", bus.cfg_last, 1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk_quiet("abort_last");
        tick();
        chk("abort_last_after_done", bus.done, 0);

        // Reset while stalled on row 1.
        push_beats(0, 2, 2, 1);
        send(0, 2, 2);
        tick();
        tick();
        bus.cfg_ready = 1'b0;
        #1 reset = 1'b1;
        cur_m = 3; cur_h = 0; cur_w = 0;
        #1;
        chk_reset_vals("mid_reset");
        @(posedge clk);
        #1 reset = 1'b0;
        bus.cfg_ready = 1'b1;
        tick();
        push_legal(2, 4, 1);
        send(2, 4, 1);
        tick();
        chk("post_reset_valid", bus.cfg_valid, 1);
        chk("post_reset_row", bus.cfg_row, 0);
        wait_done("post_reset");
        chk_quiet("final");

        for (int k = 0; k < 20 && exp_q.size() > 0; k++) tick();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
